string_hw_engine: RTL
=====================

Name: string_hw_engine

Overview:
- Parametrised multi-operation string accelerator and successor to the fixed 8-character String_HW block.
- Sits behind the NIOS2 custom-peripheral wrapper.
- Operands: software loads two NUL-padded strings A/B and an operation index, then raises go. The block processes LANES characters per cycle and raises done with Result.
- New over String_HW:
  - configurable string length and lane count
  - case toggle and character-count operations
  - error flag for illegal index
  - busy status
  - deterministic latency independent of data

Parameters:
- MAX_BLOCKS, 2, number of 32-bit words per operand; NUM_CHARS = 4*MAX_BLOCKS.
- LANES, 4, characters processed per cycle. Must divide NUM_CHARS; elaboration error otherwise.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (reset=0 resets)
- go  in  1  level request; sampled in IDLE
- index  in  3  operation select
- A  in  [0:NUM_CHARS-1][7:0]  operand string; byte 0 is first character
- B  in  [0:NUM_CHARS-1][7:0]  second operand (compare string / search char in B[0])
- done  out  1  result valid
- busy  out  1  operation in progress (LEN or RUN)
- error  out  1  illegal index accepted
- Result  out  [0:NUM_CHARS-1][7:0]  string result, or zero-extended integer (LSB in byte NUM_CHARS-1)

Behaviour:
- Strings:
  - len(X) = index of first NUL byte, or NUM_CHARS if none.
  - Bytes at or past len are "padding".
- Ops, with P = NUM_CHARS/LANES:
  - 0 COMPARE: Result = 1 iff A[i]==B[i] for all i <= len(A) (i < NUM_CHARS); else 0.
  - 1 UPPER: 'a'..'z' minus 0x20; other bytes copied.
  - 2 LOWER: 'A'..'Z' plus 0x20; other bytes copied.
  - 3 REVERSE: Result[len-1-i] = A[i] for i < len(A); Result[i] = 0 for i >= len(A).
  - 4 TOGGLE: swap case of letters; other bytes copied.
  - 5 COUNT: Result = number of i < len(A) with A[i]==B[0]; 0 if B[0]==0. Width: clog2(NUM_CHARS+1) bits, zero-extended.
  - 6,7: illegal.
- FSM states: IDLE, LEN, RUN, DONE.
  - IDLE, go=1:
    - latch A, B, index; clear Result and error.
    - chunk counter := 0.
    - next state: LEN for op 3; RUN for ops 0,1,2,4,5; DONE with error=1 and Result=0 for ops 6/7.
  - LEN: scan LANES bytes/cycle for first NUL; after P cycles -> RUN, counter reset.
  - RUN:
    - one chunk (LANES chars, indices c*LANES..c*LANES+LANES-1) per cycle.
    - after P cycles -> DONE.
    - compare uses a sticky mismatch flag; a byte counts only when its index <= len(A).
  - DONE: done=1.
    - stays while go=1.
    - go=0 -> IDLE next cycle.
    - If go is already 0 on entry, done is a one-cycle pulse.
- Latency, counting from the edge sampling go=1 in IDLE to the edge where done rises:
  - 1+P cycles for ops 0,1,2,4,5
  - 1+2P for op 3
  - 1 for illegal ops
- Data independence: no early termination; latency does not depend on the data.
- busy = 1 in LEN/RUN only.
- During LEN/RUN, changes to go, index, A, B are ignored (operands are latched).
- Result holds its value from DONE through IDLE until the next accepted go.
- Reset (async, any state): state=IDLE; done=0, busy=0, error=0, Result=0; latched operands and counters cleared. An operation in flight is abandoned with no output.
- Reset release: first go is accepted on the first rising edge with reset=1.

Decomposition:
- Package string_hw_pkg:
  - op enum op_t (OP_CMP=0, OP_UPPER, OP_LOWER, OP_REV, OP_TOGGLE, OP_COUNT)
  - state enum state_t
  - char constants NUL, CASE_DELTA=8'h20
  - functions is_upper, is_lower
- Sub-module string_hw_lane: combinational single-character unit.
  - inputs: op, a, b, b0, valid (index < len).
  - outputs: transformed byte, equal bit, match bit.
  - instantiated LANES times in string_hw_engine.
  - string_hw_engine holds the FSM, counters, length register, reverse addressing and result register.

Test Plan (MAX_BLOCKS=2, LANES=4; go held until done):
- op0, A="abcdefgh", B="abcadead" -> done 3 cycles after go, Result=0. Then A=B="abcdefgh" -> Result=1.
- op0, A="ab\0\0\0\0\0\0", B="ab\0xyzzz" -> Result=1 (padding after terminator ignored). Then B="ac" padded -> Result=0.
- ops 1/2/4 on "AbCd!9ef":
  - 1 -> "ABCD!9EF"
  - 2 -> "abcd!9ef"
  - 4 -> "aBcD!9EF"
  - each latency 3.
- op3 on "Hello!" padded -> "!olleH\0\0", done after 5 cycles, busy=1 for 4 cycles. Then "abcdefgh" (no NUL) -> "hgfedcba".
- op5, A="banana", B[0]='a' -> Result=3. Then B[0]=0 -> Result=0. Then index=7 -> done after 1 cycle, error=1, Result=0.
- Reset and handshake corners:
  - assert reset=0 mid-RUN of op3 -> done/busy/Result 0 immediately; after release, op1 on "ab" -> "AB".
  - go dropped mid-RUN -> op still completes; done pulses for exactly 1 cycle.

Source files
------------

// File: rtl/string_hw_pkg.sv
// Shared types, constants and character-class helpers for the
// string engine and its per-character lane.
package string_hw_pkg;

   typedef enum logic [2:0] {
      OP_CMP    = 3'd0,
      OP_UPPER  = 3'd1,
      OP_LOWER  = 3'd2,
      OP_REV    = 3'd3,
      OP_TOGGLE = 3'd4,
      OP_COUNT  = 3'd5
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LEN,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [7:0] NUL        = 8'h00;
   localparam logic [7:0] CASE_DELTA = 8'h20;

   function automatic logic is_upper(input logic [7:0] c);
      return (c >= 8'h41) && (c <= 8'h5A);
   endfunction

   function automatic logic is_lower(input logic [7:0] c);
      return (c >= 8'h61) && (c <= 8'h7A);
   endfunction

endpackage

// File: rtl/string_hw_lane.sv
// Combinational single-character unit: case transform, equality
// against the compare string and match against the search character.
module string_hw_lane
   import string_hw_pkg::*;
(
   input  op_t        op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] b0,
   input  logic       valid,
   output logic [7:0] y,
   output logic       eq,
   output logic       match
);

   always_comb begin
      y = a;
      case (op)
         OP_UPPER: begin
            if (is_lower(a)) y = a - CASE_DELTA;
         end
         OP_LOWER: begin
            if (is_upper(a)) y = a + CASE_DELTA;
         end
         OP_TOGGLE: begin
            if (is_lower(a))      y = a - CASE_DELTA;
            else if (is_upper(a)) y = a + CASE_DELTA;
         end
         default: y = a;
      endcase
   end

   assign eq    = (a == b);
   assign match = valid && (b0 != NUL) && (a == b0);

endmodule

// File: rtl/string_hw_engine.sv
// Multi-operation string accelerator: LANES characters per cycle,
// fixed latency, registered done/busy/error/Result.
module string_hw_engine
   import string_hw_pkg::*;
#(
   parameter  int MAX_BLOCKS = 2,
   parameter  int LANES      = 4,
   localparam int NUM_CHARS  = 4 * MAX_BLOCKS
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        go,
   input  logic [2:0]                  index,
   input  logic [0:NUM_CHARS-1][7:0]   A,
   input  logic [0:NUM_CHARS-1][7:0]   B,
   output logic                        done,
   output logic                        busy,
   output logic                        error,
   output logic [0:NUM_CHARS-1][7:0]   Result
);

   localparam int P     = NUM_CHARS / LANES;
   localparam int IDX_W = $clog2(NUM_CHARS);
   localparam int LEN_W = $clog2(NUM_CHARS + 1);

   if ((NUM_CHARS % LANES) != 0) begin : g_lanes_chk
      $error("LANES must divide NUM_CHARS");
   end

   state_t                      state_q, state_d;
   op_t                         op_q, op_d;
   logic [0:NUM_CHARS-1][7:0]   a_q, a_d, b_q, b_d;
   logic [0:NUM_CHARS-1][7:0]   result_q, result_d;
   logic [LEN_W-1:0]            len_q, len_d;
   logic [LEN_W-1:0]            count_q, count_d;
   logic [IDX_W-1:0]            cnt_q, cnt_d;
   logic                        nul_seen_q, nul_seen_d;
   logic                        mismatch_q, mismatch_d;
   logic                        done_q, done_d;
   logic                        busy_q, busy_d;
   logic                        error_q, error_d;

   logic [IDX_W-1:0]              base;
   logic [LANES-1:0][IDX_W-1:0]   ch_idx, rev_src;
   logic [LANES-1:0][7:0]         ch_a, ch_b, ch_y;
   logic [LANES-1:0]              ch_nul, ch_le, ch_lt;
   logic [LANES-1:0]              ch_eq, ch_match, rev_ok;

   assign base = IDX_W'(cnt_q * LANES);

   // ch_le: index <= len(A), ch_lt: index < len(A), tracked across chunks
   always_comb begin
      logic seen;
      seen = nul_seen_q;
      for (int k = 0; k < LANES; k++) begin
         ch_idx[k]  = base + IDX_W'(k);
         ch_a[k]    = a_q[ch_idx[k]];
         ch_b[k]    = b_q[ch_idx[k]];
         ch_nul[k]  = (ch_a[k] == NUL);
         ch_le[k]   = !seen;
         seen       = seen | ch_nul[k];
         ch_lt[k]   = !seen;
         rev_ok[k]  = LEN_W'(ch_idx[k]) < len_q;
         rev_src[k] = IDX_W'(len_q - LEN_W'(1) - LEN_W'(ch_idx[k]));
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      string_hw_lane u_lane (
         .op    (op_q),
         .a     (ch_a[k]),
         .b     (ch_b[k]),
         .b0    (b_q[0]),
         .valid (ch_lt[k]),
         .y     (ch_y[k]),
         .eq    (ch_eq[k]),
         .match (ch_match[k])
      );
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      result_d   = result_q;
      len_d      = len_q;
      count_d    = count_q;
      cnt_d      = cnt_q;
      nul_seen_d = nul_seen_q;
      mismatch_d = mismatch_q;
      error_d    = error_q;
      done_d     = (state_q == S_DONE);

      case (state_q)
         S_IDLE: begin
            if (go) begin
               a_d        = A;
               b_d        = B;
               result_d   = '0;
               error_d    = 1'b0;
               cnt_d      = '0;
               len_d      = LEN_W'(NUM_CHARS);
               count_d    = '0;
               nul_seen_d = 1'b0;
               mismatch_d = 1'b0;
               if (index > 3'd5) begin
                  error_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  op_d    = op_t'(index);
                  state_d = (op_t'(index) == OP_REV) ? S_LEN : S_RUN;
               end
            end
         end

         S_LEN: begin
            for (int k = 0; k < LANES; k++) begin
               if (ch_nul[k] && (len_d == LEN_W'(NUM_CHARS)))
                  len_d = LEN_W'(ch_idx[k]);
            end
            if (cnt_q == IDX_W'(P - 1)) begin
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_RUN: begin
            nul_seen_d = nul_seen_q | (|ch_nul);
            for (int k = 0; k < LANES; k++) begin
               if (ch_le[k] && !ch_eq[k]) mismatch_d = 1'b1;
               count_d = count_d + LEN_W'(ch_match[k]);
            end
            case (op_q)
               OP_UPPER, OP_LOWER, OP_TOGGLE: begin
                  for (int k = 0; k < LANES; k++)
                     result_d[ch_idx[k]] = ch_y[k];
               end
               OP_REV: begin
                  for (int k = 0; k < LANES; k++)
                     result_d[ch_idx[k]] = rev_ok[k] ? a_q[rev_src[k]] : NUL;
               end
               default: ;
            endcase
            if (cnt_q == IDX_W'(P - 1)) begin
               cnt_d   = '0;
               state_d = S_DONE;
               if (op_q == OP_CMP)
                  result_d = {{(8*NUM_CHARS-1){1'b0}}, !mismatch_d};
               else if (op_q == OP_COUNT)
                  result_d = {{(8*NUM_CHARS-LEN_W){1'b0}}, count_d};
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DONE: begin
            if (!go) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_LEN) || (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         op_q       <= OP_CMP;
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         len_q      <= '0;
         count_q    <= '0;
         cnt_q      <= '0;
         nul_seen_q <= 1'b0;
         mismatch_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         result_q   <= result_d;
         len_q      <= len_d;
         count_q    <= count_d;
         cnt_q      <= cnt_d;
         nul_seen_q <= nul_seen_d;
         mismatch_q <= mismatch_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         error_q    <= error_d;
      end
   end

   assign done   = done_q;
   assign busy   = busy_q;
   assign error  = error_q;
   assign Result = result_q;

endmodule
